// File: rtl/dmem_access_ctrl.sv
// ============================================================================
// dmem_access_ctrl : two-port arbiter/sequencer for a byte-wide data memory
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_access_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_i,
  input  logic [1:0]             we_i,
  input  logic [1:0][1:0]        size_i,
  input  logic [1:0][ADDR_W-1:0] addr_i,
  input  logic [1:0][31:0]       wdata_i,
  output logic [1:0]             done_o,
  output logic                   err_o,
  output logic [31:0]            rdata_o,
  output logic                   busy_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic                   mem_we_o,
  output logic                   mem_re_o,
  output logic [7:0]             mem_wdata_o,
  input  logic [7:0]             mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                port_q, port_d;
  logic                pref_q, pref_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [2:0]          nbytes_q, nbytes_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         acc_q, acc_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                re_prev_q;

  logic                gnt;
  logic [1:0]          gnt_size;
  logic [ADDR_W-1:0]   gnt_addr;
  logic                gnt_bad;
  logic [1:0]          byte_idx;

  // Winner of the current arbitration and the legality of its request
  always_comb begin
    gnt      = (req_i == 2'b11) ? pref_q : req_i[1];
    gnt_size = size_i[gnt];
    gnt_addr = addr_i[gnt];
    gnt_bad  = (gnt_size == 2'b11) ||
               ((gnt_size == 2'b01) && gnt_addr[0]) ||
               ((gnt_size == 2'b10) && (gnt_addr[1:0] != 2'b00));
  end

  // Big-endian: the first byte cycle carries the most significant byte
  assign byte_idx = 2'(nbytes_q - 3'd1 - cnt_q);

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    pref_d      = pref_q;
    we_d        = we_q;
    err_d       = err_q;
    nbytes_d    = nbytes_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    acc_d       = acc_q;
    rdata_d     = rdata_q;
    done_o      = 2'b00;
    err_o       = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_re_o    = 1'b0;
    mem_wdata_o = 8'h00;

    // Read data returns one cycle after its strobe
    if (re_prev_q) begin
      acc_d = {acc_q[23:0], mem_rdata_i};
    end

    case (state_q)
      S_IDLE: begin
        if (req_i != 2'b00) begin
          port_d  = gnt;
          we_d    = we_i[gnt];
          addr_d  = gnt_addr;
          wdata_d = wdata_i[gnt];
          if (req_i == 2'b11) begin
            pref_d = ~pref_q;
          end
          if (gnt_bad) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d    = 1'b0;
            cnt_d    = 3'd0;
            acc_d    = 32'h0;
            nbytes_d = 3'(3'd1 << gnt_size);
            state_d  = S_RUN;
          end
        end
      end

      S_RUN: begin
        mem_addr_o = addr_q + ADDR_W'(cnt_q);
        if (we_q) begin
          mem_we_o    = 1'b1;
          mem_wdata_o = wdata_q[{byte_idx, 3'b000} +: 8];
        end else begin
          mem_re_o = 1'b1;
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == nbytes_q - 3'd1) begin
          state_d = we_q ? S_DONE : S_DRAIN;
        end
      end

      S_DRAIN: begin
        rdata_d = acc_d;
        state_d = S_DONE;
      end

      S_DONE: begin
        done_o[port_q] = 1'b1;
        err_o          = err_q;
        state_d        = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      port_q    <= 1'b0;
      pref_q    <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      nbytes_q  <= 3'd0;
      cnt_q     <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      acc_q     <= 32'h0;
      rdata_q   <= 32'h0;
      re_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      pref_q    <= pref_d;
      we_q      <= we_d;
      err_q     <= err_d;
      nbytes_q  <= nbytes_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      acc_q     <= acc_d;
      rdata_q   <= rdata_d;
      re_prev_q <= mem_re_o;
    end
  end

  assign rdata_o = rdata_q;
  assign busy_o  = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
// ============================================================================
// tb_dmem_access_ctrl : scoreboard bench for dmem_access_ctrl
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             req0, req1;
  logic [1:0]       we;
  logic [1:0][1:0]  size;
  logic [1:0][7:0]  addr;
  logic [1:0][31:0] wdata;
  logic [1:0]       done_o;
  logic             err_o;
  logic [31:0]      rdata_o;
  logic             busy_o;
  logic [7:0]       mem_addr_o;
  logic             mem_we_o;
  logic             mem_re_o;
  logic [7:0]       mem_wdata_o;
  logic [7:0]       mem_rdata;

  dmem_access_ctrl #(.ADDR_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       ({req1, req0}),
    .we_i        (we),
    .size_i      (size),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .done_o      (done_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .busy_o      (busy_o),
    .mem_addr_o  (mem_addr_o),
    .mem_we_o    (mem_we_o),
    .mem_re_o    (mem_re_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata)
  );

  // Physical memory seen by the DUT, synchronous read
  logic [7:0] tb_mem [256] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_we_o) tb_mem[mem_addr_o] <= mem_wdata_o;
    if (mem_re_o) mem_rdata <= tb_mem[mem_addr_o];
  end

  // Reference model state: memory contents and arbitration preference
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  bit pref = 1'b0;

  typedef struct {
    int          port;
    bit          rd;
    bit          err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] wq[$];
  logic [7:0]  rq[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nb(input logic [1:0] s);
    return 1 << s;
  endfunction

  function automatic bit is_err(input logic [1:0] s, input logic [7:0] a);
    return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
  endfunction

  // Cycles from the request-issue cycle to the done pulse
  function automatic int lat(input bit w, input logic [1:0] s, input logic [7:0] a);
    if (is_err(s, a)) return 1;
    return w ? nb(s) + 1 : nb(s) + 2;
  endfunction

  task automatic predict(input int p, input bit w, input logic [1:0] s, input logic [7:0] a,
                         input logic [31:0] d, input int exp_cyc);
    exp_t        e;
    logic [31:0] r;
    logic [7:0]  ba;
    int          n;
    r = 32'h0;
    e.port = p;
    e.rd   = !w;
    e.err  = is_err(s, a);
    e.cyc  = exp_cyc;
    if (!e.err) begin
      n = nb(s);
      for (int i = 0; i < n; i++) begin
        ba = a + 8'(i);
        if (w) begin
          wq.push_back({ba, d[8*(n-1-i) +: 8]});
          ref_mem[ba] = d[8*(n-1-i) +: 8];
        end else begin
          rq.push_back(ba);
          r = {r[23:0], ref_mem[ba]};
        end
      end
    end
    e.rdata = r;
    sbq.push_back(e);
  endtask

  task automatic set_port(input int p, input bit w, input logic [1:0] s, input logic [7:0] a,
                          input logic [31:0] d);
    we[p]    = w;
    size[p]  = s;
    addr[p]  = a;
    wdata[p] = d;
  endtask

  task automatic wait_done(input int p);
    bit got;
    int n;
    got = 1'b0;
    n   = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      got = done_o[p];
      n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout: port %0d got no done, expected done within 60 cycles", p);
    end
    @(posedge clk);
    #1;
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  task automatic single(input int p, input bit w, input logic [1:0] s, input logic [7:0] a,
                        input logic [31:0] d);
    set_port(p, w, s, a, d);
    predict(p, w, s, a, d, cyc + lat(w, s, a));
    if (p == 0) req0 = 1'b1;
    else        req1 = 1'b1;
    wait_done(p);
  endtask

  task automatic dual(input bit w0, input logic [1:0] s0, input logic [7:0] a0, input logic [31:0] d0,
                      input bit w1, input logic [1:0] s1, input logic [7:0] a1, input logic [31:0] d1);
    int win, lose, lw, ll, k;
    bit          ww, wl;
    logic [1:0]  sw, sl;
    logic [7:0]  aw, al;
    logic [31:0] dw, dl;
    set_port(0, w0, s0, a0, d0);
    set_port(1, w1, s1, a1, d1);
    win  = pref ? 1 : 0;
    lose = 1 - win;
    pref = !pref;
    ww = win ? w1 : w0;  sw = win ? s1 : s0;  aw = win ? a1 : a0;  dw = win ? d1 : d0;
    wl = win ? w0 : w1;  sl = win ? s0 : s1;  al = win ? a0 : a1;  dl = win ? d0 : d1;
    k  = cyc;
    lw = lat(ww, sw, aw);
    ll = lat(wl, sl, al);
    predict(win, ww, sw, aw, dw, k + lw);
    predict(lose, wl, sl, al, dl, k + lw + 1 + ll);
    req0 = 1'b1;
    req1 = 1'b1;
    fork
      wait_done(win);
      wait_done(lose);
    join
  endtask

  // Monitor: memory strobes and completions against the scoreboard queues
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] wexp;
    logic [7:0]  rexp;
    if (rst_n) begin
      if (mem_we_o || mem_re_o) check("strobe_exclusive", {31'h0, mem_we_o & mem_re_o}, 32'h0);
      if (mem_we_o) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got write to %0h, expected no write", mem_addr_o);
        end else begin
          wexp = wq.pop_front();
          check("wr_addr", {24'h0, mem_addr_o}, {24'h0, wexp[15:8]});
          check("wr_data", {24'h0, mem_wdata_o}, {24'h0, wexp[7:0]});
        end
      end
      if (mem_re_o) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: got read of %0h, expected no read", mem_addr_o);
        end else begin
          rexp = rq.pop_front();
          check("rd_addr", {24'h0, mem_addr_o}, {24'h0, rexp});
        end
      end
      if (done_o != 2'b00) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done_o=%b, expected none", done_o);
        end else begin
          e = sbq.pop_front();
          check("done_port", {30'h0, done_o}, (e.port == 1) ? 32'h2 : 32'h1);
          check("err", {31'h0, err_o}, {31'h0, e.err});
          check("latency_cycle", cyc, e.cyc);
          if (e.rd && !e.err) check("rdata", rdata_o, e.rdata);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected bench end before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          w;
    logic [1:0]  s;
    logic [7:0]  a;
    logic [31:0] d;
    int          p;

    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    we    = '0;
    size  = '0;
    addr  = '0;
    wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", {30'h0, done_o}, 32'h0);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    check("rst_err", {31'h0, err_o}, 32'h0);
    check("rst_strobes", {30'h0, mem_we_o, mem_re_o}, 32'h0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_mem_addr", {24'h0, mem_addr_o}, 32'h0);
    check("rst_mem_wdata", {24'h0, mem_wdata_o}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Simultaneous word reads: port 0 first from reset, then port 1 after the flip
    dual(1'b0, 2'd2, 8'h10, 32'h0, 1'b0, 2'd2, 8'h20, 32'h0);
    dual(1'b0, 2'd2, 8'h14, 32'h0, 1'b0, 2'd2, 8'h24, 32'h0);

    single(0, 1'b1, 2'd2, 8'h10, 32'hDEADBEEF);
    single(0, 1'b0, 2'd2, 8'h10, 32'h0);
    single(0, 1'b0, 2'd0, 8'h13, 32'h0);
    single(1, 1'b1, 2'd1, 8'h21, 32'h1234);
    single(1, 1'b1, 2'd2, 8'h22, 32'h12345678);
    single(1, 1'b0, 2'd3, 8'h20, 32'h0);
    single(0, 1'b1, 2'd0, 8'hFF, 32'h0000005A);
    single(1, 1'b0, 2'd0, 8'hFF, 32'h0);
    single(0, 1'b1, 2'd1, 8'h40, 32'hCAFEBABE);
    single(1, 1'b0, 2'd1, 8'h40, 32'h0);

    // Reset during the third byte cycle of a word store
    set_port(0, 1'b1, 2'd2, 8'h30, 32'h11223344);
    wq.push_back({8'h30, 8'h11});
    wq.push_back({8'h31, 8'h22});
    wq.push_back({8'h32, 8'h33});
    ref_mem[8'h30] = 8'h11;
    ref_mem[8'h31] = 8'h22;
    req0 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_done", {30'h0, done_o}, 32'h0);
    check("midrst_busy", {31'h0, busy_o}, 32'h0);
    check("midrst_strobes", {30'h0, mem_we_o, mem_re_o}, 32'h0);
    check("midrst_mem_addr", {24'h0, mem_addr_o}, 32'h0);
    check("midrst_rdata", rdata_o, 32'h0);
    req0 = 1'b0;
    pref = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    single(0, 1'b0, 2'd2, 8'h30, 32'h0);

    for (int t = 0; t < 60; t++) begin
      p = int'($urandom_range(1, 0));
      w = 1'($urandom);
      s = 2'($urandom_range(3, 0));
      a = 8'($urandom_range(63, 0));
      d = $urandom;
      if ($urandom_range(3, 0) != 0) begin
        if (s == 2'd1) a[0] = 1'b0;
        if (s == 2'd2) a[1:0] = 2'b00;
      end
      if ($urandom_range(3, 0) == 0) begin
        dual(w, s, a, d, 1'($urandom), 2'($urandom_range(2, 0)),
             8'($urandom_range(15, 0) * 4), $urandom);
      end else begin
        single(p, w, s, a, d);
      end
    end

    repeat (4) @(posedge clk);
    check("scoreboard_empty", sbq.size(), 32'h0);
    check("write_queue_empty", wq.size(), 32'h0);
    check("read_queue_empty", rq.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
